// File: rtl/data_mem_arbiter_pkg.sv
// data_mem_arbiter_pkg: FSM state encodings and access-size masks shared by the data memory arbiter.
package data_mem_arbiter_pkg;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;
endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; the last-served pointer register lives in the parent.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt,
  output logic       o_next_last
);
  logic w_g1;
  // m1 wins when it is alone, or when both ask and m0 was served last
  assign w_g1        = i_req[1] && (!i_req[0] || !i_last);
  assign o_gnt       = {w_g1, i_req[0] && !w_g1};
  assign o_next_last = w_g1 || (!i_req[0] && i_last);
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter and fixed 3-cycle sequencer between the CPU (m0) and
// loader (m1) ports and the single-port data memory.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [MASK_W-1:0] m0_mask,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [MASK_W-1:0] m1_mask,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_ce,
  output logic              mem_we,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [MASK_W-1:0] mem_rmask,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic [1:0]        r_state, w_next_state, w_pick;
  logic              r_last, r_owner, r_we, w_next_last, w_take, w_acc, w_resp;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [MASK_W-1:0] r_mask;

  rr_arb2 u_arb (
    .i_req      ({m1_req, m0_req}),
    .i_last     (r_last),
    .o_gnt      (w_pick),
    .o_next_last(w_next_last)
  );

  assign w_take = (r_state == IDLE) && |w_pick;
  assign w_acc  = r_state == ACCESS;
  assign w_resp = r_state == RESP;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;

  always_comb w_next_state = w_take ? ACCESS : w_acc ? RESP : IDLE;

  // gnt is gated by rst_n so a held request cannot show a grant during reset
  always_comb begin
    m0_gnt    = rst_n && (r_state == IDLE) && w_pick[0];
    m1_gnt    = rst_n && (r_state == IDLE) && w_pick[1];
    m0_rvalid = w_resp && !r_owner;
    m1_rvalid = w_resp && r_owner;
    busy      = w_acc || w_resp;
    mem_ce    = w_acc;
    mem_we    = w_acc && r_we;
    mem_rd    = w_acc && !r_we;
    mem_addr  = w_acc ? r_addr : '0;
    mem_wdata = w_acc ? r_wdata : '0;
    mem_wmask = (w_acc && r_we) ? r_mask : '0;
    mem_rmask = (w_acc && !r_we) ? r_mask : '0;
    rdata     = r_rdata;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mask  <= '0;
      r_rdata <= '0;
    end else begin
      if (w_take) begin
        r_last  <= w_next_last;
        r_owner <= w_pick[1];
        r_we    <= w_pick[1] ? m1_we : m0_we;
        r_addr  <= w_pick[1] ? m1_addr : m0_addr;
        r_wdata <= w_pick[1] ? m1_wdata : m0_wdata;
        r_mask  <= w_pick[1] ? m1_mask : m0_mask;
      end
      if (w_acc && !r_we) r_rdata <= mem_rdata;
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: randomized and directed checks of data_mem_arbiter against a
// transaction-level memory/arbitration model kept in the bench.
module tb_data_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_mask, m1_mask;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, busy;
  logic        mem_ce, mem_we, mem_rd;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask, mem_rmask;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] exp_rdata;
  bit          last_srv;

  typedef struct {
    int          wcyc;
    logic        g_other, ce, we, rd, acc_gnt, acc_busy, rv, rv_other, resp_busy, resp_ce;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wmask, rmask;
  } obs_t;

  data_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_mask(m0_mask),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_mask(m1_mask),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .rdata(rdata), .busy(busy),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rmask(mem_rmask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // memory semantics: 0001 byte, 0011 half, anything else full word
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] m);
    merge = (m == 4'b0001) ? {old[31:8], wd[7:0]} : (m == 4'b0011) ? {old[31:16], wd[15:0]} : wd;
  endfunction
  function automatic logic [31:0] rsel(input logic [31:0] w, input logic [3:0] m);
    rsel = (m == 4'b0001) ? {24'd0, w[7:0]} : (m == 4'b0011) ? {16'd0, w[15:0]} : w;
  endfunction

  always @(posedge clk)
    if (mem_ce && mem_we) mem[mem_addr[11:2]] <= merge(mem[mem_addr[11:2]], mem_wdata, mem_wmask);
  assign mem_rdata = (mem_ce && mem_rd) ? rsel(mem[mem_addr[11:2]], mem_rmask) : 32'd0;

  task automatic model(input bit p, input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
    if (we) ref_mem[a[11:2]] = merge(ref_mem[a[11:2]], wd, m);
    else    exp_rdata = rsel(ref_mem[a[11:2]], m);
    last_srv = p;
  endtask

  task automatic drive(input bit p, input logic req, input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
    if (p) begin m1_req = req; m1_we = we; m1_addr = a; m1_wdata = wd; m1_mask = m; end
    else   begin m0_req = req; m0_we = we; m0_addr = a; m0_wdata = wd; m0_mask = m; end
  endtask

  // one complete transaction from port p, observed cycle by cycle
  task automatic access(input bit p, input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m, input bit hold, output obs_t o);
    @(negedge clk);
    drive(p, 1'b1, we, a, wd, m);
    #2;
    o.wcyc = 0;
    while (!(p ? m1_gnt : m0_gnt) && o.wcyc < 20) begin @(negedge clk); #2; o.wcyc++; end
    o.g_other = p ? m0_gnt : m1_gnt;
    @(negedge clk);
    if (!hold) begin if (p) m1_req = 1'b0; else m0_req = 1'b0; end
    #2;
    o.ce = mem_ce; o.we = mem_we; o.rd = mem_rd; o.addr = mem_addr; o.wdata = mem_wdata;
    o.wmask = mem_wmask; o.rmask = mem_rmask; o.acc_gnt = m0_gnt | m1_gnt; o.acc_busy = busy;
    @(negedge clk);
    #2;
    o.rv = p ? m1_rvalid : m0_rvalid; o.rv_other = p ? m0_rvalid : m1_rvalid;
    o.resp_busy = busy; o.resp_ce = mem_ce; o.rdata = rdata;
    if (p) m1_req = 1'b0; else m0_req = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    #3;
    n_tests++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy, mem_ce, mem_we, mem_rd, mem_wmask, mem_rmask} !== 16'd0 || (mem_addr | mem_wdata | rdata) !== 32'd0) begin
      n_fail++; $display("FAIL reset_state: ctl=%b data_or=%h want 0", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy, mem_ce, mem_we, mem_rd}, mem_addr | mem_wdata | rdata);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    exp_rdata = 32'd0; last_srv = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    access(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, o);
    model(0, 1'b0, 32'h0, 32'h0, 4'hF);
    n_tests++;
    if (o.rdata !== exp_rdata) begin n_fail++; $display("FAIL reset_preread: rdata=%h want %h", o.rdata, exp_rdata); end
    // write to 0x20 aborted by reset in its ACCESS cycle
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF);
    @(negedge clk);
    m0_req = 1'b0;
    #2;
    n_tests++;
    if ({mem_ce, mem_we} !== 2'b11) begin n_fail++; $display("FAIL reset_pre_abort: ce/we=%b want 11", {mem_ce, mem_we}); end
    rst_n = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
    #1;
    n_tests++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy, mem_ce, mem_we, mem_rd, mem_wmask, mem_rmask} !== 16'd0 || (mem_addr | mem_wdata | rdata) !== 32'd0) begin
      n_fail++; $display("FAIL reset_async: ctl=%b data_or=%h want 0", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy, mem_ce, mem_we, mem_rd}, mem_addr | mem_wdata | rdata);
    end
    exp_rdata = 32'd0; last_srv = 1'b1;
    @(negedge clk); m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_tests++;
      if ({m0_rvalid, m1_rvalid, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_no_rvalid: rv0/rv1/busy=%b want 000", {m0_rvalid, m1_rvalid, busy}); end
      @(negedge clk);
    end
    drive(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    #2;
    n_tests++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL reset_first_contention: m0/m1 gnt=%b want 10", {m0_gnt, m1_gnt}); end
    model(0, 1'b0, 32'h20, 32'h0, 4'hF);
    @(negedge clk); m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk); #2;
    n_tests++;
    if (m0_rvalid !== 1'b1 || rdata !== exp_rdata) begin n_fail++; $display("FAIL reset_aborted_write: rv=%b rdata=%h want 1 %h", m0_rvalid, rdata, exp_rdata); end
  endtask

  task automatic test_write_read();
    obs_t o;
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, o);
    model(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    n_tests++;
    if (o.wcyc !== 0 || {o.ce, o.we, o.rd} !== 3'b110 || o.addr !== 32'h10 || o.wdata !== 32'hDEADBEEF || o.wmask !== 4'hF || o.rmask !== 4'h0) begin
      n_fail++; $display("FAIL wr_cmd: wcyc=%0d cwr=%b a=%h d=%h wm=%h rm=%h want 0 110 10 deadbeef f 0", o.wcyc, {o.ce, o.we, o.rd}, o.addr, o.wdata, o.wmask, o.rmask);
    end
    n_tests++;
    if ({o.rv, o.rv_other, o.resp_ce} !== 3'b100 || o.rdata !== exp_rdata) begin
      n_fail++; $display("FAIL wr_resp: rv/oth/ce=%b rdata=%h want 100 %h", {o.rv, o.rv_other, o.resp_ce}, o.rdata, exp_rdata);
    end
    access(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, o);
    model(0, 1'b0, 32'h10, 32'h0, 4'hF);
    n_tests++;
    if ({o.ce, o.we, o.rd} !== 3'b101 || o.wmask !== 4'h0 || o.rmask !== 4'hF || o.rv !== 1'b1 || o.rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rd_word: cwr=%b wm=%h rm=%h rv=%b rdata=%h want 101 0 f 1 deadbeef", {o.ce, o.we, o.rd}, o.wmask, o.rmask, o.rv, o.rdata);
    end
  endtask

  task automatic test_byte_merge();
    obs_t o;
    access(1, 1'b1, 32'h10, 32'h000000AB, 4'b0001, 0, o);
    model(1, 1'b1, 32'h10, 32'h000000AB, 4'b0001);
    n_tests++;
    if (o.wmask !== 4'b0001 || o.rv !== 1'b1 || o.rv_other !== 1'b0) begin
      n_fail++; $display("FAIL byte_wr: wm=%b rv=%b oth=%b want 0001 1 0", o.wmask, o.rv, o.rv_other);
    end
    access(1, 1'b0, 32'h10, 32'h0, 4'hF, 0, o);
    model(1, 1'b0, 32'h10, 32'h0, 4'hF);
    n_tests++;
    if (o.rdata !== 32'hDEADBEAB) begin n_fail++; $display("FAIL byte_merge_word: rdata=%h want deadbeab", o.rdata); end
    access(1, 1'b0, 32'h10, 32'h0, 4'b0011, 0, o);
    model(1, 1'b0, 32'h10, 32'h0, 4'b0011);
    n_tests++;
    if (o.rdata !== 32'h0000BEAB || o.rmask !== 4'b0011) begin n_fail++; $display("FAIL byte_merge_half: rdata=%h rm=%b want 0000beab 0011", o.rdata, o.rmask); end
  endtask

  task automatic test_contention();
    int order[$];
    int gcyc[$];
    bit owner = 1'b0;
    bit exp_p;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    for (int c = 0; c < 18; c++) begin
      #2;
      if (m0_gnt | m1_gnt) begin order.push_back(int'(m1_gnt)); gcyc.push_back(c); owner = m1_gnt; end
      n_tests++;
      if ((m0_gnt && m1_gnt) || (m0_rvalid && owner) || (m1_rvalid && !owner) || ((m0_rvalid | m1_rvalid) && rdata !== rsel(ref_mem[owner ? 0 : 4], 4'hF))) begin
        n_fail++; $display("FAIL contention_cycle%0d: gnt=%b rv=%b owner=%0d rdata=%h", c, {m1_gnt, m0_gnt}, {m1_rvalid, m0_rvalid}, owner, rdata);
      end
      @(negedge clk);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    n_tests++;
    if (order.size() != 6) begin n_fail++; $display("FAIL contention_count: grants=%0d want 6", order.size()); end
    exp_p = !last_srv;
    foreach (order[i]) begin
      n_tests++;
      if (order[i] != int'(exp_p) || gcyc[i] != 3 * i) begin
        n_fail++; $display("FAIL contention_grant%0d: port=%0d cycle=%0d want port=%0d cycle=%0d", i, order[i], gcyc[i], exp_p, 3 * i);
      end
      model(exp_p, 1'b0, exp_p ? 32'h0 : 32'h10, 32'h0, 4'hF);
      exp_p = !exp_p;
    end
  endtask

  task automatic test_pending();
    int rv0 = -1;
    int g1 = -1;
    int rv1 = -1;
    logic [31:0] rd1 = 32'h0;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    for (int c = 0; c < 10; c++) begin
      #2;
      if (m0_rvalid && rv0 < 0) rv0 = c;
      if (m1_gnt && g1 < 0) g1 = c;
      if (m1_rvalid && rv1 < 0) begin rv1 = c; rd1 = rdata; end
      @(negedge clk);
      if (c == 0) begin m0_req = 1'b0; drive(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF); end
      if (c == g1) m1_req = 1'b0;
    end
    m1_req = 1'b0;
    model(0, 1'b0, 32'h0, 32'h0, 4'hF);
    model(1, 1'b0, 32'h10, 32'h0, 4'hF);
    n_tests++;
    if (rv0 != 2 || g1 != 3) begin n_fail++; $display("FAIL pending_gnt: m0_rvalid@%0d m1_gnt@%0d want 2 3", rv0, g1); end
    n_tests++;
    if (rv1 != 5 || rd1 !== exp_rdata) begin n_fail++; $display("FAIL pending_drop: m1_rvalid@%0d rdata=%h want 5 %h", rv1, rd1, exp_rdata); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, o);
    model(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    access(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, o);
    model(0, 1'b0, 32'h0, 32'h0, 4'hF);
    n_tests++;
    if (o.wcyc !== 0 || o.rdata !== 32'h00000040) begin n_fail++; $display("FAIL b2b_rd0: wcyc=%0d rdata=%h want 0 00000040", o.wcyc, o.rdata); end
    access(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, o);
    model(0, 1'b0, 32'h10, 32'h0, 4'hF);
    n_tests++;
    if (o.wcyc !== 0 || o.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_rd10: wcyc=%0d rdata=%h want 0 deadbeef", o.wcyc, o.rdata); end
    access(1, 1'b1, 32'h30, 32'h5A5A5A5A, 4'hF, 0, o);
    model(1, 1'b1, 32'h30, 32'h5A5A5A5A, 4'hF);
    n_tests++;
    if (o.rv !== 1'b1 || o.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_hold: rv=%b rdata=%h want 1 deadbeef", o.rv, o.rdata); end
  endtask

  task automatic test_random();
    obs_t o;
    bit p, hold;
    logic we;
    logic [31:0] a, wd, r;
    logic [3:0] m;
    for (int i = 0; i < 40; i++) begin
      p = 1'($urandom_range(0, 1));
      hold = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      r = $urandom;
      a = r & 32'hFFFF_F03F;
      wd = $urandom;
      case ($urandom_range(0, 3))
        0: m = 4'b0001;
        1: m = 4'b0011;
        2: m = 4'b1111;
        default: m = 4'($urandom_range(0, 15));
      endcase
      access(p, we, a, wd, m, hold, o);
      model(p, we, a, wd, m);
      n_tests++;
      if (o.wcyc !== 0 || o.g_other !== 1'b0 || {o.ce, o.we, o.rd} !== {1'b1, we, !we} || o.addr !== a || o.acc_gnt !== 1'b0 || o.acc_busy !== 1'b1) begin
        n_fail++; $display("FAIL rand%0d_cmd: wcyc=%0d oth=%b cwr=%b a=%h gnt=%b busy=%b want 0 0 %b %h 0 1", i, o.wcyc, o.g_other, {o.ce, o.we, o.rd}, o.addr, o.acc_gnt, o.acc_busy, {1'b1, we, !we}, a);
      end
      n_tests++;
      if ((we && o.wdata !== wd) || o.wmask !== (we ? m : 4'h0) || o.rmask !== (we ? 4'h0 : m)) begin
        n_fail++; $display("FAIL rand%0d_data: d=%h wm=%h rm=%h want d=%h wm=%h rm=%h", i, o.wdata, o.wmask, o.rmask, wd, we ? m : 4'h0, we ? 4'h0 : m);
      end
      n_tests++;
      if ({o.rv, o.rv_other, o.resp_ce, o.resp_busy} !== 4'b1001 || o.rdata !== exp_rdata) begin
        n_fail++; $display("FAIL rand%0d_resp: rv/oth/ce/busy=%b rdata=%h want 1001 %h", i, {o.rv, o.rv_other, o.resp_ce, o.resp_busy}, o.rdata, exp_rdata);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin mem[i] = 32'd0; ref_mem[i] = 32'd0; end
    mem[0] = 32'h00000040;
    ref_mem[0] = 32'h00000040;
    test_reset();
    test_write_read();
    test_byte_merge();
    test_contention();
    test_pending();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
